// File: rtl/div_seq_param.sv
// Parametrised multi-cycle restoring divider with a busy/done handshake.
// It also flags divide-by-zero and has a per-operation signed mode.
// One operation is in flight at a time. A result takes W+1 edges from the ld edge.
module div_seq_param #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         sgn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic [W-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         dz
);

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e         state_q, state_d;
  logic [W:0]     rem_q, rem_d;     // partial remainder, one spare bit
  logic [W-1:0]   dvd_q, dvd_d;     // dividend magnitude, shifts into quotient
  logic [W-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   r_q, r_d;
  logic           done_q, done_d;
  logic           dz_q, dz_d;

  // Datapath for one restoring step plus the operand magnitudes.
  logic [W+1:0]   shifted;
  logic [W+1:0]   trial;
  logic           trial_neg;
  logic [W:0]     rem_next;
  logic [W-1:0]   q_next;
  logic [W-1:0]   q_fin;
  logic [W-1:0]   r_fin;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;

  // Single restoring iteration and final sign correction
  always_comb begin
    shifted   = {rem_q, dvd_q[W-1]};
    trial     = shifted - {2'b00, dvs_q};
    trial_neg = trial[W+1];
    rem_next  = trial_neg ? shifted[W:0] : trial[W:0];
    q_next    = {dvd_q[W-2:0], ~trial_neg};
    q_fin     = qneg_q ? (~q_next + W'(1)) : q_next;
    r_fin     = rneg_q ? (~rem_next[W-1:0] + W'(1)) : rem_next[W-1:0];
    // Most-negative maps to 2^(W-1), which still fits W bits unsigned.
    a_mag     = (sgn && a[W-1]) ? (~a + W'(1)) : a;
    b_mag     = (sgn && b[W-1]) ? (~b + W'(1)) : b;
  end

  // Next-state logic: load/zero-divisor handling in idle, iteration in calc
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    y_d     = y_q;
    r_d     = r_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    unique case (state_q)
      StIdle: begin
        if (ld) begin
          if (b == '0) begin
            // Resolved at the load edge; no iteration.
            y_d    = '1;
            r_d    = a;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = '0;
            qneg_d  = sgn & (a[W-1] ^ b[W-1]);
            rneg_d  = sgn & a[W-1];
            cnt_d   = CW'(W);
            dz_d    = 1'b0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = rem_next;
        dvd_d = q_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          y_d     = q_fin;
          r_d     = r_fin;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      y_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      y_q     <= y_d;
      r_q     <= r_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign y    = y_q;
  assign r    = r_q;
  assign busy = (state_q == StCalc);
  assign done = done_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_div_seq_param.sv
// Directed bench for div_seq_param at W=4 plus a randomised W=8 pass against integer arithmetic.
module tb_div_seq_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ld4 = 1'b0;
  logic       ld8 = 1'b0;
  logic       sgn_in = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic [3:0] y4, r4;
  logic [7:0] y8, r8;
  logic       busy4, done4, dz4, busy8, done8, dz8;
  bit         use8 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  div_seq_param #(.W(4)) u_div4 (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld4),
    .sgn  (sgn_in),
    .a    (a_in[3:0]),
    .b    (b_in[3:0]),
    .y    (y4),
    .r    (r4),
    .busy (busy4),
    .done (done4),
    .dz   (dz4)
  );

  div_seq_param u_div8 (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld8),
    .sgn  (sgn_in),
    .a    (a_in),
    .b    (b_in),
    .y    (y8),
    .r    (r8),
    .busy (busy8),
    .done (done8),
    .dz   (dz8)
  );

  always #5 clk = ~clk;

  logic [7:0] y_s, r_s;
  logic       busy_s, done_s, dz_s;
  assign y_s    = use8 ? y8 : {4'b0, y4};
  assign r_s    = use8 ? r8 : {4'b0, r4};
  assign busy_s = use8 ? busy8 : busy4;
  assign done_s = use8 ? done8 : done4;
  assign dz_s   = use8 ? dz8 : dz4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the load edge.
  task automatic issue(input bit w8, input bit s, input logic [7:0] a, input logic [7:0] b);
    use8   = w8;
    sgn_in = s;
    a_in   = a;
    b_in   = b;
    if (w8) ld8 = 1'b1;
    else    ld4 = 1'b1;
    @(negedge clk);
    ld4  = 1'b0;
    ld8  = 1'b0;
    a_in = ~a;
    b_in = ~b;
  endtask

  // n counts edges since the load edge; stops at the negedge where done is seen.
  task automatic wait_done(input int n0, output int n, output int nb);
    n  = n0;
    nb = 0;
    while (!done_s && n < 40) begin
      if (busy_s) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  int n, nb, pulses;
  logic [7:0] ra, rb, ey, er;
  bit         rs;
  int         sa, sb, q, rm;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_y", y4, 0);
    check("rst_r", r4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_dz", dz4, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 11 / 2 unsigned
    issue(0, 0, 8'h0B, 8'h02);
    wait_done(1, n, nb);
    check("u11_2_lat", n, 5);
    check("u11_2_busy", nb, 4);
    check("u11_2_y", y_s, 4'h5);
    check("u11_2_r", r_s, 4'h1);
    check("u11_2_dz", dz_s, 0);

    // 9 / 8 issued in the done cycle
    issue(0, 0, 8'h09, 8'h08);
    check("b2b_done_drop", done_s, 0);
    check("b2b_busy", busy_s, 1);
    wait_done(1, n, nb);
    check("u9_8_lat", n, 5);
    check("u9_8_y", y_s, 4'h1);
    check("u9_8_r", r_s, 4'h1);

    // Signed -7 / 2
    issue(0, 1, 8'h09, 8'h02);
    wait_done(1, n, nb);
    check("s_m7_2_y", y_s, 4'hD);
    check("s_m7_2_r", r_s, 4'hF);

    // Signed overflow -8 / -1
    issue(0, 1, 8'h08, 8'h0F);
    wait_done(1, n, nb);
    check("s_ovf_lat", n, 5);
    check("s_ovf_y", y_s, 4'h8);
    check("s_ovf_r", r_s, 4'h0);

    // Divide by zero
    issue(0, 0, 8'h06, 8'h00);
    wait_done(1, n, nb);
    check("dz_lat", n, 1);
    check("dz_busy", busy_s, 0);
    check("dz_y", y_s, 4'hF);
    check("dz_r", r_s, 4'h6);
    check("dz_flag", dz_s, 1);
    @(negedge clk);
    check("dz_pulse_one", done_s, 0);
    issue(0, 0, 8'h0B, 8'h02);
    check("dz_cleared", dz_s, 0);
    wait_done(1, n, nb);
    check("after_dz_y", y_s, 4'h5);

    // ld while busy is ignored
    @(negedge clk);
    issue(0, 0, 8'h0B, 8'h02);
    @(negedge clk);
    ld4  = 1'b1;
    a_in = 8'h0F;
    b_in = 8'h01;
    @(negedge clk);
    ld4 = 1'b0;
    wait_done(3, n, nb);
    check("ign_lat", n, 5);
    check("ign_y", y_s, 4'h5);
    check("ign_r", r_s, 4'h1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_s) pulses++;
    end
    check("ign_extra_done", pulses, 0);
    check("ign_idle", busy_s, 0);

    // Asynchronous reset mid-operation
    issue(0, 0, 8'h0B, 8'h02);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_y", y_s, 0);
    check("arst_r", r_s, 0);
    check("arst_busy", busy_s, 0);
    check("arst_done", done_s, 0);
    check("arst_dz", dz_s, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_s || busy_s) pulses++;
    end
    check("arst_no_done", pulses, 0);
    issue(0, 0, 8'h0B, 8'h02);
    wait_done(1, n, nb);
    check("arst_redo_lat", n, 5);
    check("arst_redo_y", y_s, 4'h5);
    check("arst_redo_r", r_s, 4'h1);

    // W=8 randomised against integer reference
    for (int i = 0; i < 200; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 17 == 3) rb = 8'h00;
      if (i % 50 == 7) begin
        rs = 1'b1;
        ra = 8'h80;
        rb = 8'hFF;
      end
      if (rb == 8'h00) begin
        ey = 8'hFF;
        er = ra;
      end else if (rs) begin
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        q  = sa / sb;
        rm = sa % sb;
        ey = 8'(q);
        er = 8'(rm);
      end else begin
        ey = ra / rb;
        er = ra % rb;
      end
      issue(1, rs, ra, rb);
      wait_done(1, n, nb);
      check("w8_lat", n, (rb == 8'h00) ? 1 : 9);
      check("w8_y", y_s, ey);
      check("w8_r", r_s, er);
      check("w8_dz", dz_s, (rb == 8'h00) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
